sr_ff_bank: RTL and testbench

//   Bank of WIDTH clocked SR flip-flops sharing one clock, reset and enable.

---
 rtl/sr_bank_pkg.sv | 12 +
 rtl/sr_bank_cell.sv | 50 +++++
 rtl/sr_ff_bank.sv | 115 +++++++++++
 tb/tb_sr_ff_bank.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sr_bank_pkg.sv
// Shared definitions for the SR flip-flop bank.
// Mode encoding for resolving simultaneous set and reset.
package sr_bank_pkg;

  typedef logic [1:0] sr_mode_t;

  localparam sr_mode_t MODE_HOLD = 2'd0;
  localparam sr_mode_t MODE_SET  = 2'd1;
  localparam sr_mode_t MODE_RST  = 2'd2;
  localparam sr_mode_t MODE_TGL  = 2'd3;

endpackage

// File: rtl/sr_bank_cell.sv
// One clocked SR channel with selectable S=R=1 resolution.
// Async active-low reset loads RST_BIT.
module sr_cell
  import sr_bank_pkg::*;
#(
  parameter int   MODE    = 0,
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  output logic q
);

  localparam sr_mode_t M = sr_mode_t'(MODE[1:0]);

  logic q_d;
  logic q_q;

  // next state: set, clear, hold, or mode-resolved conflict
  always_comb begin
    q_d = q_q;
    if (en) begin
      unique case ({s, r})
        2'b10: q_d = 1'b1;
        2'b01: q_d = 1'b0;
        2'b11: begin
          unique case (M)
            MODE_SET: q_d = 1'b1;
            MODE_RST: q_d = 1'b0;
            MODE_TGL: q_d = ~q_q;
            default:  q_d = q_q;
          endcase
        end
        default: q_d = q_q;
      endcase
    end
  end

  // flag register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= RST_BIT;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH SR flip-flops with conflict flags and counter.
// Optional SR_BANK_SYNC_EN adds 2-flop synchronizers on s and r.
module sr_ff_bank
  import sr_bank_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               MODE    = 0,
  parameter int               CNT_W   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $error("sr_ff_bank: illegal MODE %0d", MODE);
  end

  logic [WIDTH-1:0] s_u;
  logic [WIDTH-1:0] r_u;

`ifdef SR_BANK_SYNC_EN
  logic [WIDTH-1:0] s_m_d, s_m_q, s_s_d, s_s_q;
  logic [WIDTH-1:0] r_m_d, r_m_q, r_s_d, r_s_q;

  // synchronizer stage inputs
  always_comb begin
    s_m_d = s;
    r_m_d = r;
    s_s_d = s_m_q;
    r_s_d = r_m_q;
  end

  // two-flop synchronizers for set and reset requests
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_m_q <= '0;
      s_s_q <= '0;
      r_m_q <= '0;
      r_s_q <= '0;
    end else begin
      s_m_q <= s_m_d;
      s_s_q <= s_s_d;
      r_m_q <= r_m_d;
      r_s_q <= r_s_d;
    end
  end

  assign s_u = s_s_q;
  assign r_u = r_s_q;
`else
  assign s_u = s;
  assign r_u = r;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .MODE    (MODE),
      .RST_BIT (RST_VAL[i])
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .s   (s_u[i]),
      .r   (r_u[i]),
      .q   (q[i])
    );
  end

  assign qn = ~q;

  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] conflict_d, conflict_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign hit = s_u & r_u;

  // clear first so a same-cycle conflict wins; saturate the count
  always_comb begin
    conflict_d = conflict_q;
    cnt_d      = cnt_q;
    if (clr_err) begin
      conflict_d = '0;
      cnt_d      = '0;
    end
    if (en) begin
      conflict_d = conflict_d | hit;
      if (|hit && cnt_d != {CNT_W{1'b1}})
        cnt_d = cnt_d + CNT_W'(1);
    end
  end

  // conflict flag and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict_q <= '0;
      cnt_q      <= '0;
    end else begin
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end

  assign conflict     = conflict_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed bench for sr_ff_bank, one instance per MODE.
// Optional SR_BANK_SYNC_EN build checks the 3-cycle latency.
module tb_sr_ff_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] s;
  logic [3:0] r;
  logic       clr_err;

  logic [3:0] q   [4];
  logic [3:0] qn  [4];
  logic [3:0] cf  [4];
  logic [2:0] cnt [4];

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    sr_ff_bank #(
      .WIDTH   (4),
      .MODE    (m),
      .CNT_W   (3),
      .RST_VAL (4'b0000)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .s            (s),
      .r            (r),
      .clr_err      (clr_err),
      .q            (q[m]),
      .qn           (qn[m]),
      .conflict     (cf[m]),
      .conflict_cnt (cnt[m])
    );
  end

  task automatic chk(input string tag, input int m,
                     input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s mode%0d obs=%h exp=%h", tag, m, obs, exp);
  endtask

  task automatic chk_q(input string tag, input int m,
                       input logic [3:0] eq);
    chk({tag, ".q"}, m, {4'h0, q[m]}, {4'h0, eq});
    chk({tag, ".qn"}, m, {4'h0, qn[m]}, {4'h0, ~eq});
  endtask

  task automatic chk_err(input string tag, input int m,
                         input logic [3:0] ecf, input logic [2:0] ecnt);
    chk({tag, ".cf"}, m, {4'h0, cf[m]}, {4'h0, ecf});
    chk({tag, ".cnt"}, m, {5'h0, cnt[m]}, {5'h0, ecnt});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [3:0] sv,
                       input logic [3:0] rv, input logic c);
    en      = e;
    s       = sv;
    r       = rv;
    clr_err = c;
  endtask

  logic [3:0] exp3 [4];

  initial begin
    exp3[0] = 4'b0001;
    exp3[1] = 4'b0011;
    exp3[2] = 4'b0000;
    exp3[3] = 4'b0010;

    rst = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    #3;
    for (int m = 0; m < 4; m++) begin
      chk_q("rst", m, 4'h0);
      chk_err("rst", m, 4'h0, 3'd0);
    end
    tick();
    @(negedge clk);
    rst = 1'b1;

`ifndef SR_BANK_SYNC_EN
    // set / clear
    drive(1'b1, 4'b0101, 4'b0000, 1'b0);
    tick();
    for (int m = 0; m < 4; m++) chk_q("set", m, 4'b0101);
    drive(1'b1, 4'b0000, 4'b0001, 1'b0);
    tick();
    for (int m = 0; m < 4; m++) chk_q("clr", m, 4'b0100);

    // reach q=0001, then S=R=1 on 0011
    drive(1'b1, 4'b0001, 4'b0100, 1'b0);
    tick();
    for (int m = 0; m < 4; m++) chk_q("pre", m, 4'b0001);
    drive(1'b1, 4'b0011, 4'b0011, 1'b0);
    tick();
    for (int m = 0; m < 4; m++) begin
      chk_q("mode", m, exp3[m]);
      chk_err("mode", m, 4'b0011, 3'd1);
    end

    // saturation: 10 hit cycles from cnt=1
    drive(1'b1, 4'b0001, 4'b0001, 1'b0);
    repeat (5) tick();
    for (int m = 0; m < 4; m++) chk_err("sat6", m, 4'b0011, 3'd6);
    tick();
    for (int m = 0; m < 4; m++) chk_err("sat7", m, 4'b0011, 3'd7);
    repeat (4) tick();
    for (int m = 0; m < 4; m++) chk_err("nowrap", m, 4'b0011, 3'd7);
    drive(1'b1, 4'b0001, 4'b0001, 1'b1);
    tick();
    for (int m = 0; m < 4; m++) chk_err("clrhit", m, 4'b0001, 3'd1);

    // en=0 holds everything, no conflict detection
    drive(1'b1, 4'b0101, 4'b1010, 1'b0);
    tick();
    for (int m = 0; m < 4; m++) chk_q("q5", m, 4'b0101);
    drive(1'b0, 4'hF, 4'h0, 1'b0);
    repeat (3) tick();
    for (int m = 0; m < 4; m++) begin
      chk_q("en0", m, 4'b0101);
      chk_err("en0", m, 4'b0001, 3'd1);
    end
    drive(1'b0, 4'hF, 4'hF, 1'b0);
    tick();
    for (int m = 0; m < 4; m++) begin
      chk_q("en0hit", m, 4'b0101);
      chk_err("en0hit", m, 4'b0001, 3'd1);
    end
    drive(1'b0, 4'h0, 4'h0, 1'b1);
    tick();
    for (int m = 0; m < 4; m++) begin
      chk_q("clren0", m, 4'b0101);
      chk_err("clren0", m, 4'b0000, 3'd0);
    end

    // build q=F, cnt=5 then async reset mid-cycle
    drive(1'b1, 4'b0001, 4'b0001, 1'b0);
    repeat (5) tick();
    drive(1'b1, 4'hF, 4'h0, 1'b0);
    tick();
    for (int m = 0; m < 4; m++) begin
      chk_q("prerst", m, 4'hF);
      chk_err("prerst", m, 4'b0001, 3'd5);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    for (int m = 0; m < 4; m++) begin
      chk_q("arst", m, 4'h0);
      chk_err("arst", m, 4'h0, 3'd0);
    end
    tick();
    for (int m = 0; m < 4; m++) chk_q("arsth", m, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    for (int m = 0; m < 4; m++) chk_q("rel", m, 4'hF);
`else
    // s[2] pulse: q[2] rises only after the third edge
    drive(1'b1, 4'b0100, 4'h0, 1'b0);
    tick();
    for (int m = 0; m < 4; m++) chk_q("sync1", m, 4'h0);
    drive(1'b1, 4'h0, 4'h0, 1'b0);
    tick();
    for (int m = 0; m < 4; m++) chk_q("sync2", m, 4'h0);
    tick();
    for (int m = 0; m < 4; m++) chk_q("sync3", m, 4'b0100);
    tick();
    for (int m = 0; m < 4; m++) begin
      chk_q("sync4", m, 4'b0100);
      chk_err("sync4", m, 4'h0, 3'd0);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
